// File: rtl/dmem_commit_ctrl_if.sv
// D-cache port between the commit-side memory controller (master) and the d-cache (slave).
interface dmem_commit_ctrl_if;
   logic        dmem_read;
   logic        dmem_write;
   logic [31:0] dmem_address;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_mbe;
   logic        dmem_resp;
   logic [31:0] dmem_rdata;

   modport master (
      output dmem_read,
      output dmem_write,
      output dmem_address,
      output dmem_wdata,
      output dmem_mbe,
      input  dmem_resp,
      input  dmem_rdata
   );

   modport slave (
      input  dmem_read,
      input  dmem_write,
      input  dmem_address,
      input  dmem_wdata,
      input  dmem_mbe,
      output dmem_resp,
      output dmem_rdata
   );
endinterface

// File: rtl/dmem_commit_ctrl.sv
// Commit-side data-memory responder: performs the LD/ST at the ROB head on the d-cache port
// using addresses and store data staged per ROB entry.
module dmem_commit_ctrl #(
   parameter int unsigned ROB_DEPTH = 8,
   localparam int unsigned IdxW = $clog2(ROB_DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 addr_valid,
   input  logic [IdxW-1:0]      addr_rob_idx,
   input  logic [31:0]          addr,
   input  logic [2:0]           funct3,
   input  logic [31:0]          st_data,
   input  logic [ROB_DEPTH-1:0] allocated_rob_entries,
   input  logic [IdxW-1:0]      head_ptr,
   input  logic                 data_read,
   input  logic                 data_write,
   input  logic                 flush_in_prog,
   output logic                 data_mem_resp,
   output logic [31:0]          ld_data,
   dmem_commit_ctrl_if.master   dmem
);

   typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

   state_e               state_q;
   logic [ROB_DEPTH-1:0] tbl_valid_q;
   logic [ROB_DEPTH-1:0] tbl_we;
   logic [31:0]          tbl_addr_q   [ROB_DEPTH];
   logic [31:0]          tbl_data_q   [ROB_DEPTH];
   logic [2:0]           tbl_funct3_q [ROB_DEPTH];

   logic [IdxW-1:0] cur_idx_q;
   logic [1:0]      cur_off_q;
   logic [2:0]      cur_funct3_q;

   logic        dmem_read_q;
   logic        dmem_write_q;
   logic [31:0] dmem_address_q;
   logic [31:0] dmem_wdata_q;
   logic [3:0]  dmem_mbe_q;
   logic        data_mem_resp_q;
   logic [31:0] ld_data_q;

   logic        start;
   logic [31:0] head_addr;
   logic [31:0] head_data;
   logic [2:0]  head_funct3;
   logic [1:0]  head_off;
   logic [3:0]  head_mbe;
   logic [31:0] head_wdata;
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;
   logic [31:0] ld_ext;

   // A write to the entry currently in flight is ignored so the access stays consistent.
   always_comb begin
      tbl_we = '0;
      for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
         tbl_we[i] = addr_valid && allocated_rob_entries[i] && (addr_rob_idx == IdxW'(i))
                     && !(state_q == StReq && cur_idx_q == IdxW'(i));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tbl_valid_q <= '0;
      end else begin
         for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
            if (!allocated_rob_entries[i]) begin
               tbl_valid_q[i] <= 1'b0;
            end else if (state_q == StDone && cur_idx_q == IdxW'(i)) begin
               tbl_valid_q[i] <= 1'b0;
            end else if (tbl_we[i]) begin
               tbl_valid_q[i] <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
         if (tbl_we[i]) begin
            tbl_addr_q[i]   <= addr;
            tbl_data_q[i]   <= st_data;
            tbl_funct3_q[i] <= funct3;
         end
      end
   end

   always_comb begin
      head_addr   = tbl_addr_q[head_ptr];
      head_data   = tbl_data_q[head_ptr];
      head_funct3 = tbl_funct3_q[head_ptr];
      head_off    = head_addr[1:0];
      start       = (state_q == StIdle) && (data_read || data_write) && !flush_in_prog
                    && tbl_valid_q[head_ptr];
      case (head_funct3)
         3'b000, 3'b100: begin
            head_mbe   = 4'b0001 << head_off;
            head_wdata = {4{head_data[7:0]}};
         end
         3'b001, 3'b101: begin
            head_mbe   = 4'b0011 << {head_off[1], 1'b0};
            head_wdata = {2{head_data[15:0]}};
         end
         default: begin
            head_mbe   = 4'hF;
            head_wdata = head_data;
         end
      endcase
   end

   always_comb begin
      rd_byte = dmem.dmem_rdata[{cur_off_q, 3'b000} +: 8];
      rd_half = dmem.dmem_rdata[{cur_off_q[1], 4'b0000} +: 16];
      case (cur_funct3_q)
         3'b000:  ld_ext = {{24{rd_byte[7]}}, rd_byte};
         3'b100:  ld_ext = {24'h0, rd_byte};
         3'b001:  ld_ext = {{16{rd_half[15]}}, rd_half};
         3'b101:  ld_ext = {16'h0, rd_half};
         default: ld_ext = dmem.dmem_rdata;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= StIdle;
         cur_idx_q       <= '0;
         cur_off_q       <= '0;
         cur_funct3_q    <= '0;
         dmem_read_q     <= 1'b0;
         dmem_write_q    <= 1'b0;
         dmem_address_q  <= '0;
         dmem_wdata_q    <= '0;
         dmem_mbe_q      <= '0;
         data_mem_resp_q <= 1'b0;
         ld_data_q       <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  state_q        <= StReq;
                  cur_idx_q      <= head_ptr;
                  cur_off_q      <= head_off;
                  cur_funct3_q   <= head_funct3;
                  // Read wins when both requests are raised together.
                  dmem_read_q    <= data_read;
                  dmem_write_q   <= !data_read;
                  dmem_address_q <= {head_addr[31:2], 2'b00};
                  dmem_wdata_q   <= head_wdata;
                  dmem_mbe_q     <= head_mbe;
               end
            end
            StReq: begin
               if (dmem.dmem_resp) begin
                  state_q         <= StDone;
                  dmem_read_q     <= 1'b0;
                  dmem_write_q    <= 1'b0;
                  data_mem_resp_q <= 1'b1;
                  ld_data_q       <= dmem_read_q ? ld_ext : 32'h0;
               end
            end
            StDone: begin
               state_q         <= StIdle;
               data_mem_resp_q <= 1'b0;
               ld_data_q       <= '0;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign dmem.dmem_read    = dmem_read_q;
   assign dmem.dmem_write   = dmem_write_q;
   assign dmem.dmem_address = dmem_address_q;
   assign dmem.dmem_wdata   = dmem_wdata_q;
   assign dmem.dmem_mbe     = dmem_mbe_q;
   assign data_mem_resp     = data_mem_resp_q;
   assign ld_data           = ld_data_q;

endmodule

// File: tb/tb_dmem_commit_ctrl.sv
// Directed bench for dmem_commit_ctrl: loads/stores of each width, stalls, flushes, async reset.
module tb_dmem_commit_ctrl;
   logic        clk;
   logic        rst;
   logic        addr_valid;
   logic [2:0]  addr_rob_idx;
   logic [31:0] addr;
   logic [2:0]  funct3;
   logic [31:0] st_data;
   logic [7:0]  allocated_rob_entries;
   logic [2:0]  head_ptr;
   logic        data_read;
   logic        data_write;
   logic        flush_in_prog;
   logic        data_mem_resp;
   logic [31:0] ld_data;

   int checks;
   int errors;

   dmem_commit_ctrl_if dmem_bus ();

   dmem_commit_ctrl #(.ROB_DEPTH(8)) dut (
      .clk                   (clk),
      .rst                   (rst),
      .addr_valid            (addr_valid),
      .addr_rob_idx          (addr_rob_idx),
      .addr                  (addr),
      .funct3                (funct3),
      .st_data               (st_data),
      .allocated_rob_entries (allocated_rob_entries),
      .head_ptr              (head_ptr),
      .data_read             (data_read),
      .data_write            (data_write),
      .flush_in_prog         (flush_in_prog),
      .data_mem_resp         (data_mem_resp),
      .ld_data               (ld_data),
      .dmem                  (dmem_bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic stage(input logic [2:0] idx, input logic [31:0] a, input logic [2:0] f3,
                        input logic [31:0] sd);
      addr_valid   = 1'b1;
      addr_rob_idx = idx;
      addr         = a;
      funct3       = f3;
      st_data      = sd;
      tick();
      addr_valid   = 1'b0;
   endtask

   // Respond on the d-cache port and check the single-cycle completion pulse.
   task automatic respond(input string tag, input logic [31:0] rdata, input logic chk_ld,
                          input logic [31:0] exp_ld);
      dmem_bus.dmem_resp  = 1'b1;
      dmem_bus.dmem_rdata = rdata;
      tick();
      dmem_bus.dmem_resp  = 1'b0;
      chk({tag, " resp_pulse"}, data_mem_resp, 1);
      chk({tag, " strobes_drop"}, {dmem_bus.dmem_read, dmem_bus.dmem_write}, 0);
      if (chk_ld) chk({tag, " ld_data"}, ld_data, exp_ld);
      data_read  = 1'b0;
      data_write = 1'b0;
      tick();
      chk({tag, " resp_one_cycle"}, data_mem_resp, 0);
   endtask

   task automatic op(input string tag, input logic rd, input logic [2:0] hd, input int dly,
                     input logic [31:0] rdata, input logic [31:0] exp_addr,
                     input logic [31:0] exp_wdata, input logic [3:0] exp_mbe,
                     input logic [31:0] exp_ld);
      head_ptr   = hd;
      data_read  = rd;
      data_write = !rd;
      tick();
      chk({tag, " rd_strobe"}, dmem_bus.dmem_read, rd);
      chk({tag, " wr_strobe"}, dmem_bus.dmem_write, !rd);
      chk({tag, " address"}, dmem_bus.dmem_address, exp_addr);
      chk({tag, " mbe"}, dmem_bus.dmem_mbe, exp_mbe);
      if (!rd) chk({tag, " wdata"}, dmem_bus.dmem_wdata, exp_wdata);
      for (int i = 0; i < dly; i++) begin
         tick();
         chk({tag, " strobe_held"}, {dmem_bus.dmem_read, dmem_bus.dmem_write}, {rd, !rd});
         chk({tag, " no_early_resp"}, data_mem_resp, 0);
      end
      respond(tag, rdata, rd, exp_ld);
   endtask

   initial begin
      checks                = 0;
      errors                = 0;
      rst                   = 1'b1;
      addr_valid            = 1'b0;
      addr_rob_idx          = '0;
      addr                  = '0;
      funct3                = '0;
      st_data               = '0;
      allocated_rob_entries = 8'hFF;
      head_ptr              = '0;
      data_read             = 1'b0;
      data_write            = 1'b0;
      flush_in_prog         = 1'b0;
      dmem_bus.dmem_resp    = 1'b0;
      dmem_bus.dmem_rdata   = '0;
      tick();
      chk("reset outputs", {data_mem_resp, dmem_bus.dmem_read, dmem_bus.dmem_write}, 0);
      chk("reset address", dmem_bus.dmem_address, 0);
      chk("reset mbe", dmem_bus.dmem_mbe, 0);
      chk("reset ld_data", ld_data, 0);
      tick();
      rst = 1'b0;
      tick();

      // Word load, response two cycles after the strobe rises.
      stage(3'd2, 32'h0000_0100, 3'b010, 32'h0);
      op("lw", 1'b1, 3'd2, 1, 32'hDEAD_BEEF, 32'h0000_0100, 32'h0, 4'hF, 32'hDEAD_BEEF);
      head_ptr  = 3'd2;
      data_read = 1'b1;
      tick();
      tick();
      chk("lw entry_cleared", dmem_bus.dmem_read, 0);
      data_read = 1'b0;
      tick();

      stage(3'd3, 32'h0000_0103, 3'b000, 32'h0);
      op("lb", 1'b1, 3'd3, 0, 32'h80FF_0000, 32'h0000_0100, 32'h0, 4'b1000, 32'hFFFF_FF80);
      stage(3'd4, 32'h0000_0103, 3'b100, 32'h0);
      op("lbu", 1'b1, 3'd4, 0, 32'h80FF_0000, 32'h0000_0100, 32'h0, 4'b1000, 32'h0000_0080);
      stage(3'd6, 32'h0000_0103, 3'b001, 32'h0);
      op("lh", 1'b1, 3'd6, 0, 32'h8001_1234, 32'h0000_0100, 32'h0, 4'b1100, 32'hFFFF_8001);
      stage(3'd1, 32'h0000_0100, 3'b101, 32'h0);
      op("lhu", 1'b1, 3'd1, 1, 32'h8001_F234, 32'h0000_0100, 32'h0, 4'b0011, 32'h0000_F234);

      stage(3'd5, 32'h0000_0206, 3'b001, 32'h1234_ABCD);
      op("sh", 1'b0, 3'd5, 2, 32'h0, 32'h0000_0204, 32'hABCD_ABCD, 4'b1100, 32'h0);
      stage(3'd7, 32'h0000_0101, 3'b000, 32'h0000_00AB);
      op("sb", 1'b0, 3'd7, 0, 32'h0, 32'h0000_0100, 32'hABAB_ABAB, 4'b0010, 32'h0);
      stage(3'd0, 32'h0000_0300, 3'b010, 32'hCAFE_F00D);
      op("sw", 1'b0, 3'd0, 0, 32'h0, 32'h0000_0300, 32'hCAFE_F00D, 4'hF, 32'h0);

      // Both requests high: read wins.
      stage(3'd2, 32'h0000_0040, 3'b010, 32'h5555_AAAA);
      head_ptr   = 3'd2;
      data_read  = 1'b1;
      data_write = 1'b1;
      tick();
      chk("both read_wins", {dmem_bus.dmem_read, dmem_bus.dmem_write}, 2'b10);
      respond("both", 32'h0BAD_F00D, 1'b1, 32'h0BAD_F00D);

      // Request before the address arrives; odd funct3 behaves as a word access.
      head_ptr  = 3'd5;
      data_read = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("early no_strobe", dmem_bus.dmem_read, 0);
      end
      addr_valid   = 1'b1;
      addr_rob_idx = 3'd5;
      addr         = 32'h0000_010A;
      funct3       = 3'b011;
      tick();
      addr_valid   = 1'b0;
      chk("early write_cycle", dmem_bus.dmem_read, 0);
      tick();
      chk("early strobe", dmem_bus.dmem_read, 1);
      chk("early address", dmem_bus.dmem_address, 32'h0000_0108);
      chk("early mbe", dmem_bus.dmem_mbe, 4'hF);
      respond("early", 32'h1357_9BDF, 1'b1, 32'h1357_9BDF);

      // Flush blocks issue; dropped allocation invalidates entries and drops writes.
      stage(3'd1, 32'h0000_0400, 3'b010, 32'h0);
      stage(3'd6, 32'h0000_0404, 3'b010, 32'h0);
      flush_in_prog = 1'b1;
      head_ptr      = 3'd1;
      data_read     = 1'b1;
      tick();
      tick();
      chk("flush no_issue", dmem_bus.dmem_read, 0);
      allocated_rob_entries = 8'h03;
      stage(3'd7, 32'h0000_0408, 3'b010, 32'h0);
      allocated_rob_entries = 8'hFF;
      flush_in_prog         = 1'b0;
      head_ptr              = 3'd6;
      tick();
      tick();
      chk("flush entry6_cleared", dmem_bus.dmem_read, 0);
      head_ptr = 3'd7;
      tick();
      tick();
      chk("flush entry7_dropped", dmem_bus.dmem_read, 0);
      head_ptr = 3'd1;
      tick();
      chk("flush entry1_kept", dmem_bus.dmem_read, 1);
      chk("flush address", dmem_bus.dmem_address, 32'h0000_0400);
      flush_in_prog = 1'b1;
      tick();
      chk("flush in_req_held", dmem_bus.dmem_read, 1);
      respond("flush_req", 32'h2468_ACE0, 1'b1, 32'h2468_ACE0);
      flush_in_prog = 1'b0;

      // Asynchronous reset while a request is outstanding.
      stage(3'd0, 32'h0000_0010, 3'b010, 32'h0);
      head_ptr  = 3'd0;
      data_read = 1'b1;
      tick();
      chk("arst strobe_up", dmem_bus.dmem_read, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst strobe_drop", {dmem_bus.dmem_read, dmem_bus.dmem_write}, 0);
      data_read          = 1'b0;
      dmem_bus.dmem_resp = 1'b1;
      tick();
      chk("arst no_resp", data_mem_resp, 0);
      rst = 1'b0;
      tick();
      dmem_bus.dmem_resp = 1'b0;
      chk("arst no_resp_after", data_mem_resp, 0);
      tick();
      chk("arst idle", {data_mem_resp, dmem_bus.dmem_read, dmem_bus.dmem_write}, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
